// File: rtl/periph_rx_arbiter.sv
// periph_rx_arbiter: round-robin merge of stream and cfg packet queues onto one RX FIFO write port
// Ports: clk/rst (async, active-high); stream_data/stream_valid and cfg_data/cfg_valid are
//        fire-and-forget push sources; rx_data/rx_wren/rx_full form the RX FIFO write port;
//        drop_clr clears the saturating stream_drops/cfg_drops overflow counters;
//        idle flags both queues empty with no push in flight.
module periph_rx_arbiter #(
    parameter int DATA_WIDTH = 29,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] stream_data,
    input  logic                  stream_valid,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_wren,
    input  logic                  rx_full,
    input  logic                  drop_clr,
    output logic [15:0]           stream_drops,
    output logic [15:0]           cfg_drops,
    output logic                  idle
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [1:0] ne, pop;
    logic [DATA_WIDTH-1:0] head [2];
    logic [15:0] drops [2];
    logic last, grant_c;

    // cfg wins a tie unless it was the one served last
    assign grant_c = ne[1] & (~ne[0] | ~last);
    assign rx_wren = |ne & ~rx_full;
    assign pop = {rx_wren & grant_c, rx_wren & ~grant_c};
    assign rx_data = grant_c ? head[1] : head[0];
    assign stream_drops = drops[0];
    assign cfg_drops = drops[1];
    assign idle = ~|ne & ~stream_valid & ~cfg_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= 1'b0;
        else if (rx_wren) last <= grant_c;
    end

    for (genvar i = 0; i < 2; i++) begin : g_q
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] din;
        logic [AW-1:0] rd_ptr, wr_ptr;
        logic [AW:0] cnt;
        logic [15:0] dcnt;
        logic valid, push, drop;
        assign valid = (i == 0) ? stream_valid : cfg_valid;
        assign din = (i == 0) ? stream_data : cfg_data;
        // a full queue still accepts a push when it pops in the same cycle
        assign push = valid & ((cnt != FULL_CNT) | pop[i]);
        assign drop = valid & ~push;
        assign ne[i] = cnt != '0;
        assign head[i] = mem[rd_ptr];
        assign drops[i] = dcnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt <= '0;
                dcnt <= '0;
            end else begin
                if (push) mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + AW'(push);
                rd_ptr <= rd_ptr + AW'(pop[i]);
                cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop[i]);
                dcnt <= drop_clr ? '0 : dcnt + 16'(drop & ~&dcnt);
            end
        end
    end
endmodule

// File: tb/tb_periph_rx_arbiter.sv
// tb_periph_rx_arbiter: randomized and directed checks of periph_rx_arbiter against a queue model
module tb_periph_rx_arbiter;
    localparam int DW = 29;
    localparam int D = 4;

    logic clk = 1'b0, rst = 1'b0;
    logic [DW-1:0] stream_data = '0, cfg_data = '0, rx_data;
    logic stream_valid = 1'b0, cfg_valid = 1'b0, rx_full = 1'b0, drop_clr = 1'b0;
    logic rx_wren, idle;
    logic [15:0] stream_drops, cfg_drops;

    int total = 0, bad = 0;

    logic [DW-1:0] sq[$], cq[$];
    int sdrop, cdrop;
    bit mlast, e_wren, e_gc, e_idle;
    logic [DW-1:0] e_data;

    periph_rx_arbiter #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .stream_data(stream_data), .stream_valid(stream_valid),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .rx_data(rx_data), .rx_wren(rx_wren), .rx_full(rx_full),
        .drop_clr(drop_clr), .stream_drops(stream_drops), .cfg_drops(cfg_drops),
        .idle(idle)
    );

    always #5 clk = ~clk;

    task drive(input bit sv, input logic [DW-1:0] sd, input bit cv, input logic [DW-1:0] cd,
               input bit full, input bit clr);
        stream_valid = sv; stream_data = sd; cfg_valid = cv; cfg_data = cd;
        rx_full = full; drop_clr = clr;
    endtask

    task model_reset;
        sq.delete(); cq.delete(); sdrop = 0; cdrop = 0; mlast = 0;
    endtask

    task model_expect;
        e_wren = (sq.size() + cq.size() > 0) && !rx_full;
        e_gc = cq.size() > 0 && (sq.size() == 0 || !mlast);
        e_data = e_gc ? cq[0] : (sq.size() > 0 ? sq[0] : '0);
        e_idle = sq.size() == 0 && cq.size() == 0 && !stream_valid && !cfg_valid;
    endtask

    task model_commit;
        if (e_wren) begin
            if (e_gc) void'(cq.pop_front()); else void'(sq.pop_front());
            mlast = e_gc;
        end
        if (stream_valid) begin
            if (sq.size() < D) sq.push_back(stream_data); else if (sdrop < 65535) sdrop++;
        end
        if (cfg_valid) begin
            if (cq.size() < D) cq.push_back(cfg_data); else if (cdrop < 65535) cdrop++;
        end
        if (drop_clr) begin sdrop = 0; cdrop = 0; end
    endtask

    task do_reset;
        drive(0, '0, 0, '0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task test_reset;
        drive(0, '0, 0, '0, 0, 0);
        rst = 1'b1;
        #2;
        total++; if (rx_wren !== 1'b0) begin bad++; $display("FAIL reset_wren got %b want 0", rx_wren); end
        total++; if (rx_data !== '0) begin bad++; $display("FAIL reset_data got %h want 0", rx_data); end
        total++; if (stream_drops !== 16'd0) begin bad++; $display("FAIL reset_sdrops got %h want 0", stream_drops); end
        total++; if (cfg_drops !== 16'd0) begin bad++; $display("FAIL reset_cdrops got %h want 0", cfg_drops); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got %b want 1", idle); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task test_single_cfg;
        do_reset();
        drive(0, '0, 1, 29'h1ABCDEF0, 0, 0);
        @(negedge clk);
        total++; if (rx_wren !== 1'b0) begin bad++; $display("FAIL single_early got %b want 0", rx_wren); end
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL single_idle_push got %b want 0", idle); end
        @(posedge clk); #1;
        drive(0, '0, 0, '0, 0, 0);
        @(negedge clk);
        total++; if (rx_wren !== 1'b1) begin bad++; $display("FAIL single_wren got %b want 1", rx_wren); end
        total++; if (rx_data !== 29'h1ABCDEF0) begin bad++; $display("FAIL single_data got %h want 1abcdef0", rx_data); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (rx_wren !== 1'b0) begin bad++; $display("FAIL single_after got %b want 0", rx_wren); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle got %b want 1", idle); end
        @(posedge clk); #1;
    endtask

    task test_same_cycle;
        do_reset();
        drive(1, 29'h11, 1, 29'h22, 0, 0);
        @(posedge clk); #1;
        drive(0, '0, 0, '0, 0, 0);
        @(negedge clk);
        total++; if (rx_wren !== 1'b1 || rx_data !== 29'h22) begin bad++; $display("FAIL same_first got %b/%h want 1/22", rx_wren, rx_data); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (rx_wren !== 1'b1 || rx_data !== 29'h11) begin bad++; $display("FAIL same_second got %b/%h want 1/11", rx_wren, rx_data); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (rx_wren !== 1'b0) begin bad++; $display("FAIL same_done got %b want 0", rx_wren); end
        total++; if (stream_drops !== 16'd0 || cfg_drops !== 16'd0) begin bad++; $display("FAIL same_drops got %h/%h want 0/0", stream_drops, cfg_drops); end
        @(posedge clk); #1;
    endtask

    task test_backpressure;
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            drive(1, DW'(n), 0, '0, 1, 0);
            @(negedge clk);
            total++; if (rx_wren !== 1'b0) begin bad++; $display("FAIL bp_hold_%0d got %b want 0", n, rx_wren); end
            @(posedge clk); #1;
        end
        drive(0, '0, 0, '0, 1, 0);
        @(negedge clk);
        total++; if (stream_drops !== 16'd2) begin bad++; $display("FAIL bp_drops got %0d want 2", stream_drops); end
        @(posedge clk); #1;
        drive(0, '0, 0, '0, 0, 0);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            total++; if (rx_wren !== 1'b1 || rx_data !== DW'(n)) begin bad++; $display("FAIL bp_drain_%0d got %b/%h want 1/%h", n, rx_wren, rx_data, n); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (rx_wren !== 1'b0) begin bad++; $display("FAIL bp_empty got %b want 0", rx_wren); end
        @(posedge clk); #1;
    endtask

    task test_both_stream;
        int writes, k, s_last, c_last;
        writes = 0; k = 0; s_last = -1; c_last = -1;
        do_reset();
        for (int n = 0; n < 20; n++) begin
            drive(1, {1'b0, 28'(n)}, 1, {1'b1, 28'(n)}, 0, 0);
            @(negedge clk);
            model_expect();
            total++; if (rx_wren !== e_wren) begin bad++; $display("FAIL both_wren_%0d got %b want %b", n, rx_wren, e_wren); end
            if (rx_wren === 1'b1) begin
                writes++;
                total++; if (rx_data[DW-1] !== (k % 2 == 0)) begin bad++; $display("FAIL both_alt_%0d got src %b want %b", k, rx_data[DW-1], k % 2 == 0); end
                if (rx_data[DW-1]) begin
                    total++; if (int'(rx_data[27:0]) <= c_last) begin bad++; $display("FAIL both_corder got %0d want >%0d", rx_data[27:0], c_last); end
                    c_last = int'(rx_data[27:0]);
                end else begin
                    total++; if (int'(rx_data[27:0]) <= s_last) begin bad++; $display("FAIL both_sorder got %0d want >%0d", rx_data[27:0], s_last); end
                    s_last = int'(rx_data[27:0]);
                end
                k++;
            end
            @(posedge clk); model_commit(); #1;
        end
        drive(0, '0, 0, '0, 1, 0);
        @(negedge clk);
        total++;
        if (int'(stream_drops) + int'(cfg_drops) != 40 - writes - (sq.size() + cq.size())) begin
            bad++; $display("FAIL both_dropsum got %0d want %0d", int'(stream_drops) + int'(cfg_drops), 40 - writes - (sq.size() + cq.size()));
        end
        total++; if (stream_drops !== 16'(sdrop) || cfg_drops !== 16'(cdrop)) begin bad++; $display("FAIL both_drops got %0d/%0d want %0d/%0d", stream_drops, cfg_drops, sdrop, cdrop); end
        @(posedge clk); #1;
    endtask

    task test_random;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 1), DW'($urandom), $urandom_range(0, 2) == 0, DW'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0);
            @(negedge clk);
            model_expect();
            total++; if (rx_wren !== e_wren) begin bad++; $display("FAIL rnd_wren_%0d got %b want %b", n, rx_wren, e_wren); end
            if (e_wren) begin
                total++; if (rx_data !== e_data) begin bad++; $display("FAIL rnd_data_%0d got %h want %h", n, rx_data, e_data); end
            end
            total++; if (idle !== e_idle) begin bad++; $display("FAIL rnd_idle_%0d got %b want %b", n, idle, e_idle); end
            total++; if (stream_drops !== 16'(sdrop) || cfg_drops !== 16'(cdrop)) begin bad++; $display("FAIL rnd_drops_%0d got %0d/%0d want %0d/%0d", n, stream_drops, cfg_drops, sdrop, cdrop); end
            @(posedge clk); model_commit(); #1;
        end
    endtask

    task test_saturate;
        do_reset();
        drive(1, 29'h5, 0, '0, 1, 0);
        repeat (D + 70000) @(posedge clk);
        #1;
        drive(0, '0, 0, '0, 1, 0);
        @(negedge clk);
        total++; if (stream_drops !== 16'hFFFF) begin bad++; $display("FAIL sat_value got %h want ffff", stream_drops); end
        total++; if (cfg_drops !== 16'h0) begin bad++; $display("FAIL sat_cfg got %h want 0", cfg_drops); end
        @(posedge clk); #1;
        drive(1, 29'h6, 0, '0, 1, 1);
        @(posedge clk); #1;
        drive(0, '0, 0, '0, 1, 0);
        @(negedge clk);
        total++; if (stream_drops !== 16'h0) begin bad++; $display("FAIL sat_clr got %h want 0", stream_drops); end
        @(posedge clk); #1;
    endtask

    task test_mid_reset;
        do_reset();
        for (int n = 0; n < D + 2; n++) begin
            drive(1, DW'(n + 100), 1, DW'(n + 200), 1, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (stream_drops !== 16'd2 || cfg_drops !== 16'd2) begin bad++; $display("FAIL mid_pre got %0d/%0d want 2/2", stream_drops, cfg_drops); end
        @(posedge clk); #1;
        drive(1, 29'h7, 1, 29'h8, 0, 0);
        rst = 1'b1;
        #1;
        total++; if (rx_wren !== 1'b0) begin bad++; $display("FAIL mid_wren got %b want 0", rx_wren); end
        total++; if (stream_drops !== 16'd0 || cfg_drops !== 16'd0) begin bad++; $display("FAIL mid_drops got %0d/%0d want 0/0", stream_drops, cfg_drops); end
        @(posedge clk); #1;
        drive(0, '0, 0, '0, 0, 0);
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            total++; if (rx_wren !== 1'b0) begin bad++; $display("FAIL mid_stale_%0d got %b/%h want 0", n, rx_wren, rx_data); end
            @(posedge clk); #1;
        end
        drive(0, '0, 1, 29'h1234, 0, 0);
        @(posedge clk); #1;
        drive(0, '0, 0, '0, 0, 0);
        @(negedge clk);
        total++; if (rx_wren !== 1'b1 || rx_data !== 29'h1234) begin bad++; $display("FAIL mid_fresh got %b/%h want 1/1234", rx_wren, rx_data); end
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        test_reset();
        test_single_cfg();
        test_same_cycle();
        test_backpressure();
        test_both_stream();
        test_random();
        test_saturate();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
